// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-outstanding-request data memory with a fixed response latency.
//   A request is accepted combinationally in IDLE. The store is committed, or
//   the load data captured, on the accept edge. The response is presented
//   latency_p cycles later and is held until the core takes it.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   reset      : asynchronous active-high reset
//   mem_in_i   : core request (write_data, valid, wen, byte_not_word, yumi)
//   addr_i     : byte address, sampled together with mem_in_i.valid
//   mem_out_o  : response (valid, yumi = request accepted, read_data)
//   busy_o     : high whenever a request is outstanding

typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
} mem_in_s;

typedef struct packed {
    logic        valid;
    logic        yumi;
    logic [31:0] read_data;
} mem_out_s;

module data_mem_responder #(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     mem_in_i,
    input  logic [31:0] addr_i,
    output mem_out_s    mem_out_o,
    output logic        busy_o
);

    localparam int unsigned Depth   = 1 << addr_width_p;
    localparam logic [3:0]  LoadCnt = 4'(latency_p - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        accept;

    logic [31:0] mem_q [Depth];

    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic [31:0]             word_rd;
    logic [7:0]              byte_rd;

    // Address bits above the storage size wrap and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:addr_width_p+2];

    assign word_idx = addr_i[addr_width_p+1:2];
    assign lane     = addr_i[1:0];
    assign word_rd  = mem_q[word_idx];
    assign byte_rd  = word_rd[{lane, 3'b000} +: 8];

    // Storage has no reset; accept is already qualified with reset.
    always_ff @(posedge clk) begin
        if (accept && mem_in_i.wen) begin
            if (mem_in_i.byte_not_word) begin
                mem_q[word_idx][{lane, 3'b000} +: 8] <= mem_in_i.write_data[7:0];
            end else begin
                mem_q[word_idx] <= mem_in_i.write_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_in_i.valid && !reset) begin
                    accept  = 1'b1;
                    state_d = StBusy;
                    cnt_d   = LoadCnt;
                    // Load data is taken now so it reflects storage at accept time.
                    if (mem_in_i.wen) begin
                        rdata_d = 32'd0;
                    end else if (mem_in_i.byte_not_word) begin
                        rdata_d = {24'd0, byte_rd};
                    end else begin
                        rdata_d = word_rd;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // A request presented during the handshake cycle waits for IDLE.
                if (mem_in_i.yumi) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
                rdata_d = 32'd0;
            end
        endcase
    end

    always_comb begin
        mem_out_o      = '0;
        mem_out_o.yumi = accept;
        if (state_q == StResp) begin
            mem_out_o.valid     = 1'b1;
            mem_out_o.read_data = rdata_q;
        end
    end

    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int unsigned AW    = 10;
    localparam int unsigned LAT   = 2;
    localparam int unsigned WORDS = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    mem_in_s     req;
    logic [31:0] addr;
    mem_out_s    rsp;
    logic        busy;

    mem_in_s     req1;
    logic [31:0] addr1;
    mem_out_s    rsp1;
    logic        busy1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.addr_width_p(AW), .latency_p(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_in_i  (req),
        .addr_i    (addr),
        .mem_out_o (rsp),
        .busy_o    (busy)
    );

    data_mem_responder #(.addr_width_p(AW), .latency_p(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .mem_in_i  (req1),
        .addr_i    (addr1),
        .mem_out_o (rsp1),
        .busy_o    (busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-addressed, time-stamped) ----------------
    logic [7:0]  mm [WORDS*4];
    bit          mk [WORDS*4];
    bit          m_pend = 1'b0;
    int          m_acc  = 0;
    logic [31:0] m_resp = '0;
    bit          m_known = 1'b0;
    int          cyc = 0;

    mem_in_s     s_req;
    logic [31:0] s_addr;
    logic        s_rst;
    bit          e_valid, e_yumi, e_busy;
    int unsigned w, b;

    initial begin
        forever begin
            @(negedge clk);
            s_req  = req;
            s_addr = addr;
            s_rst  = reset;
            e_valid = !s_rst && m_pend && (cyc - m_acc >= LAT);
            e_yumi  = !s_rst && !m_pend && s_req.valid;
            e_busy  = !s_rst && m_pend;
            check("m_valid", 32'(rsp.valid), 32'(e_valid));
            check("m_yumi", 32'(rsp.yumi), 32'(e_yumi));
            check("m_busy", 32'(busy), 32'(e_busy));
            if (!e_valid) check("m_rdata0", rsp.read_data, 32'd0);
            else if (m_known) check("m_rdata", rsp.read_data, m_resp);
            @(posedge clk);
            if (s_rst) begin
                m_pend = 1'b0;
            end else if (e_yumi) begin
                w = (s_addr / 4) % WORDS;
                b = w * 4 + s_addr % 4;
                if (s_req.wen) begin
                    if (s_req.byte_not_word) begin
                        mm[b] = s_req.write_data[7:0];
                        mk[b] = 1'b1;
                    end else begin
                        for (int k = 0; k < 4; k++) begin
                            mm[w*4+k] = s_req.write_data[8*k +: 8];
                            mk[w*4+k] = 1'b1;
                        end
                    end
                    m_resp  = 32'd0;
                    m_known = 1'b1;
                end else if (s_req.byte_not_word) begin
                    m_resp  = {24'd0, mm[b]};
                    m_known = mk[b];
                end else begin
                    m_resp  = {mm[w*4+3], mm[w*4+2], mm[w*4+1], mm[w*4]};
                    m_known = mk[w*4] && mk[w*4+1] && mk[w*4+2] && mk[w*4+3];
                end
                m_pend = 1'b1;
                m_acc  = cyc + 1;
            end else if (e_valid && s_req.yumi) begin
                m_pend = 1'b0;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit wen, input bit bnw, input logic [31:0] a, input logic [31:0] d);
        req               = '0;
        req.valid         = 1'b1;
        req.wen           = wen;
        req.byte_not_word = bnw;
        req.write_data    = d;
        addr              = a;
    endtask

    task automatic wait_valid(input string nm, input int lat);
        int n;
        n = 0;
        while (!rsp.valid && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_lat"}, n, lat);
    endtask

    // One transaction from IDLE; response held `hold` extra cycles before the handshake.
    task automatic xact(input string nm, input bit wen, input bit bnw, input logic [31:0] a,
                        input logic [31:0] d, input int hold, output logic [31:0] rd);
        send(wen, bnw, a, d);
        #1 check({nm, "_yumi"}, 32'(rsp.yumi), 32'd1);
        tick();
        req = '0;
        wait_valid(nm, LAT);
        rd = rsp.read_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({nm, "_hold_v"}, 32'(rsp.valid), 32'd1);
            check({nm, "_hold_d"}, rsp.read_data, rd);
        end
        req.yumi = 1'b1;
        tick();
        req.yumi = 1'b0;
        check({nm, "_drop"}, 32'(rsp.valid), 32'd0);
    endtask

    task automatic xact1(input bit wen, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
        int n;
        req1            = '0;
        req1.valid      = 1'b1;
        req1.wen        = wen;
        req1.write_data = d;
        addr1           = a;
        #1 check("l1_yumi", 32'(rsp1.yumi), 32'd1);
        tick();
        req1 = '0;
        check("l1_busy", 32'(busy1), 32'd1);
        n = 0;
        while (!rsp1.valid && n < 20) begin
            tick();
            n++;
        end
        check("l1_lat", n, 1);
        rd = rsp1.read_data;
        req1.yumi = 1'b1;
        tick();
        req1.yumi = 1'b0;
        check("l1_drop", 32'(rsp1.valid), 32'd0);
    endtask

    logic [31:0] rd;
    int r;

    initial begin
        reset = 1'b1;
        req   = '0;
        addr  = '0;
        req1  = '0;
        addr1 = '0;
        tick();
        tick();
        // Request offered during reset must not be accepted.
        send(1'b1, 1'b0, 32'h40, 32'h1);
        #1;
        check("rst_yumi", 32'(rsp.yumi), 32'd0);
        check("rst_valid", 32'(rsp.valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", rsp.read_data, 32'd0);
        tick();
        req   = '0;
        reset = 1'b0;
        tick();

        // Word store / load
        xact("st10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd);
        check("st10_rd", rd, 32'd0);
        xact("ld10", 1'b0, 1'b0, 32'h10, 32'h0, 0, rd);
        check("ld10_rd", rd, 32'hDEADBEEF);

        // Byte lane merge and byte load
        xact("st20", 1'b1, 1'b0, 32'h20, 32'h11223344, 0, rd);
        xact("sb22", 1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, 0, rd);
        check("sb22_rd", rd, 32'd0);
        xact("ld20", 1'b0, 1'b0, 32'h20, 32'h0, 0, rd);
        check("ld20_rd", rd, 32'h11AA3344);
        xact("lb23", 1'b0, 1'b1, 32'h23, 32'h0, 0, rd);
        check("lb23_rd", rd, 32'h00000011);

        // Response held five cycles
        xact("hold", 1'b0, 1'b0, 32'h20, 32'h0, 5, rd);
        check("hold_rd", rd, 32'h11AA3344);

        // valid held high across two loads
        send(1'b0, 1'b0, 32'h10, 32'h0);
        #1 check("b2b_yumi1", 32'(rsp.yumi), 32'd1);
        tick();
        wait_valid("b2b1", LAT);
        check("b2b_noacc", 32'(rsp.yumi), 32'd0);
        check("b2b_rd1", rsp.read_data, 32'hDEADBEEF);
        addr              = 32'h23;
        req.byte_not_word = 1'b1;
        req.yumi          = 1'b1;
        #1 check("b2b_hs_noacc", 32'(rsp.yumi), 32'd0);
        tick();
        req.yumi = 1'b0;
        check("b2b_yumi2", 32'(rsp.yumi), 32'd1);
        check("b2b_gap", 32'(rsp.valid), 32'd0);
        tick();
        req = '0;
        wait_valid("b2b2", LAT);
        check("b2b_rd2", rsp.read_data, 32'h00000011);
        req.yumi = 1'b1;
        tick();
        req.yumi = 1'b0;

        // Async reset while BUSY after a store
        send(1'b1, 1'b0, 32'h30, 32'h5);
        tick();
        req = '0;
        check("ar_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_busy0", 32'(busy), 32'd0);
        check("ar_valid0", 32'(rsp.valid), 32'd0);
        check("ar_rdata0", rsp.read_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        xact("ld30", 1'b0, 1'b0, 32'h30, 32'h0, 0, rd);
        check("ld30_rd", rd, 32'h00000005);

        // Async reset while RESP
        send(1'b0, 1'b0, 32'h10, 32'h0);
        tick();
        req = '0;
        wait_valid("arr", LAT);
        #2 reset = 1'b1;
        #1;
        check("arr_valid0", 32'(rsp.valid), 32'd0);
        check("arr_rdata0", rsp.read_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Address wrap
        xact("stwrap", 1'b1, 1'b0, 32'h1004, 32'h77, 0, rd);
        xact("ldwrap", 1'b0, 1'b0, 32'h4, 32'h0, 0, rd);
        check("ldwrap_rd", rd, 32'h00000077);

        // latency_p = 1 instance
        xact1(1'b1, 32'h8, 32'h1234, rd);
        check("l1_st_rd", rd, 32'd0);
        xact1(1'b0, 32'h8, 32'h0, rd);
        check("l1_ld_rd", rd, 32'h00001234);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r                 = $urandom_range(0, 199);
            reset             = (r == 0);
            req.valid         = ($urandom_range(0, 2) != 0);
            req.wen           = $urandom_range(0, 1) != 0;
            req.byte_not_word = $urandom_range(0, 1) != 0;
            req.write_data    = $urandom;
            req.yumi          = $urandom_range(0, 1) != 0;
            addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0;
        req   = '0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter addr_width_p, default 10: word-address width; storage is 2^addr_width_p 32-bit words.
REQ-002 Parameter latency_p, default 2: cycles from request accept to response valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_in_i  input  mem_in_s  core request: write_data[31:0], valid, wen, byte_not_word, yumi (core accepts response).
REQ-006 addr_i  input  32  byte address of request, sampled with mem_in_i.valid.
REQ-007 mem_out_o  output  mem_out_s  response: valid, yumi (request accepted), read_data[31:0].
REQ-008 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-009 States: IDLE, BUSY, RESP; exactly one active.
REQ-010 IDLE: mem_out_o.yumi SHALL be combinationally high in any cycle where mem_in_i.valid=1; low otherwise and in all other states.
REQ-011 Accept edge (IDLE, valid=1): capture wen, byte_not_word, write_data, addr_i; load latency counter with latency_p-1; go to BUSY.
REQ-012 Word index = addr_i[addr_width_p+1:2]; byte lane = addr_i[1:0]; addr_i[1:0] ignored for word ops; higher address bits ignored (wrap modulo storage).
REQ-013 Store (wen=1) SHALL update storage on the accept edge; word store writes all 32 bits; byte store writes only lane bits [8*lane+7:8*lane] from write_data[7:0], little-endian.
REQ-014 BUSY: counter decrements each cycle; at counter=0, go to RESP next edge; total valid latency after accept edge = latency_p cycles.
REQ-015 Load read_data: word = stored word; byte = selected lane zero-extended to 32 bits; value reflects storage as of accept edge.
REQ-016 Store read_data SHALL be 32'b0.
REQ-017 RESP: mem_out_o.valid=1, read_data stable; held until mem_in_i.yumi=1.
REQ-018 RESP with yumi=1: go to IDLE next edge; no new request accepted that cycle, even if valid=1.
REQ-019 read_data SHALL be 32'b0 whenever mem_out_o.valid=0.
REQ-020 mem_in_i.yumi outside RESP SHALL be ignored; mem_in_i.valid outside IDLE SHALL be ignored (no second capture, no storage write).
REQ-021 Back-to-back: request valid in the cycle after RESP->IDLE SHALL be accepted immediately (one IDLE cycle minimum between responses).
REQ-022 latency_p=1: BUSY lasts one cycle; valid asserted one cycle after accept edge.

Reset
REQ-023 reset=1 SHALL asynchronously force state IDLE, counter 0, captured request cleared; mem_out_o.valid=0, mem_out_o.yumi=0, read_data=0, busy_o=0.
REQ-024 Reset mid-BUSY/RESP SHALL abandon the pending response; a store already written on its accept edge remains written.
REQ-025 Storage contents are not cleared by reset; loads from never-written words return undefined data (bench must not check them).
REQ-026 First request accepted no earlier than the first posedge after reset deasserts.

Verification
REQ-027 Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 (latency_p=2) -> yumi in accept cycle, valid exactly 2 cycles later, read_data=0xDEADBEEF; store response read_data=0.
REQ-028 Word store 0x20=0x11223344, byte store addr 0x22 data 0xAA, word load 0x20 -> 0x11AA3344; byte load 0x23 -> 0x00000011.
REQ-029 Load held in RESP with yumi low 5 cycles -> valid and read_data stable 5 cycles; yumi high -> valid low next cycle; new valid same cycle not accepted (yumi=0).
REQ-030 valid held high continuously across two loads -> second yumi exactly one cycle after first response's yumi handshake; ordering and data correct.
REQ-031 Reset asserted while BUSY after store 0x30=0x5 -> outputs 0 immediately (async); after release, load 0x30 -> 0x00000005.
REQ-032 Address wrap (addr_width_p=10): store addr 0x1004 = 0x77, load addr 0x4 -> 0x00000077; latency_p=1 build -> valid one cycle after accept.
